// File: rtl/nios2_c_gpio_bidir_edge.sv
// WIDTH-bit bidirectional GPIO Avalon-MM slave with input synchronisers,
// per-bit edge capture (W1C) and a maskable level interrupt.
module nios2_c_gpio_bidir_edge #(
    parameter int unsigned      WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0,
    parameter int unsigned      EDGE_TYPE   = 0,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    inout  wire  [WIDTH-1:0] bidir_port,
    output logic             irq
);

    localparam int unsigned WARM_MAX = SYNC_STAGES + 1;
    localparam int unsigned WCW      = $clog2(WARM_MAX + 1);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_DIR    = 3'd1;
    localparam logic [2:0] A_MASK   = 3'd2;
    localparam logic [2:0] A_EDGE   = 3'd3;
    localparam logic [2:0] A_OUTSET = 3'd4;
    localparam logic [2:0] A_OUTCLR = 3'd5;

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WCW-1:0]   r_warm;
    logic [31:0]      r_readdata;

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_s;
    logic             w_warm_done;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_w1c;
    logic [WIDTH-1:0] w_data_out_nxt;
    logic [WIDTH-1:0] w_dir_nxt;
    logic [WIDTH-1:0] w_mask_nxt;
    logic [WIDTH-1:0] w_edge_cap_nxt;
    logic [31:0]      w_readdata_nxt;

    // Pin drivers: output-enabled bits drive data_out, others float.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_pin
        assign bidir_port[i] = r_dir[i] ? r_data_out[i] : 1'bz;
    end

    if (WIDTH < 32) begin : g_unused
        logic w_unused_wdata;
        assign w_unused_wdata = ^writedata[31:WIDTH];
    end

    assign w_wr        = chipselect & ~write_n;
    assign w_wd        = writedata[WIDTH-1:0];
    assign w_s         = r_sync[SYNC_STAGES-1];
    assign w_warm_done = (r_warm == WCW'(WARM_MAX));

    // Register updates, edge detection and read mux.
    always_comb begin
        w_data_out_nxt = r_data_out;
        w_dir_nxt      = r_dir;
        w_mask_nxt     = r_mask;
        w_w1c          = '0;
        w_edge         = '0;
        w_readdata_nxt = '0;

        if (w_wr) begin
            case (address)
                A_DATA:   w_data_out_nxt = w_wd;
                A_DIR:    w_dir_nxt      = w_wd;
                A_MASK:   w_mask_nxt     = w_wd;
                A_EDGE:   w_w1c          = w_wd;
                A_OUTSET: w_data_out_nxt = r_data_out | w_wd;
                A_OUTCLR: w_data_out_nxt = r_data_out & ~w_wd;
                default:  ;
            endcase
        end

        if (w_warm_done) begin
            case (EDGE_TYPE)
                0:       w_edge = w_s & ~r_prev;
                1:       w_edge = ~w_s & r_prev;
                default: w_edge = w_s ^ r_prev;
            endcase
        end

        // A new edge outranks a simultaneous clear.
        w_edge_cap_nxt = (r_edge_cap & ~w_w1c) | w_edge;

        case (address)
            A_DATA:  w_readdata_nxt = 32'(w_s);
            A_DIR:   w_readdata_nxt = 32'(r_dir);
            A_MASK:  w_readdata_nxt = 32'(r_mask);
            A_EDGE:  w_readdata_nxt = 32'(r_edge_cap);
            default: w_readdata_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= RESET_OUT;
            r_dir      <= RESET_DIR;
            r_mask     <= '0;
            r_edge_cap <= '0;
            r_prev     <= '0;
            r_warm     <= '0;
            r_readdata <= '0;
            for (int k = 0; k < int'(SYNC_STAGES); k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_data_out <= w_data_out_nxt;
            r_dir      <= w_dir_nxt;
            r_mask     <= w_mask_nxt;
            r_edge_cap <= w_edge_cap_nxt;
            r_prev     <= w_s;
            r_readdata <= w_readdata_nxt;
            if (!w_warm_done) begin
                r_warm <= r_warm + WCW'(1);
            end
            r_sync[0] <= bidir_port;
            for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge_cap & r_mask);

endmodule
